// File: rtl/rgb_pwm_breathe.sv
// -----------------------------------------------------------------------------
// rgb_pwm_breathe
//
// Three-channel PWM generator that drives the per-colour modulation inputs of
// the iCE40 RGB LED current driver. Duty values arrive over a valid/ready port
// and go into shadow registers. All three channels copy the shadows into their
// active duty registers at the same instant, on a PWM period boundary, so a
// period never mixes an old and a new duty.
//
// Optional feature (macro RGB_PWM_BREATHE_EN): adds the `breathe` input and an
// UP/DOWN ramp engine. While breathe is high, the engine replaces blue's duty
// with a triangle wave that moves one step per period.
//
// Parameters:
//   WIDTH     PWM resolution in bits; one period is 2^WIDTH phase ticks
//   PRESCALE  clk cycles per phase tick (1..65535)
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   duty_valid    duty write request
//   duty_ready    write can be accepted this cycle (low only on commit cycles)
//   duty_sel      0=red, 1=green, 2=blue, 3=none (write accepted and dropped)
//   duty_data     duty value
//   enable        run PWM; when low, counters are held at 0 and outputs are low
//   breathe       blue breathing mode (only with RGB_PWM_BREATHE_EN)
//   pwm_r/g/b     registered PWM outputs
//   period_start  one-cycle pulse on the first cycle of each PWM period
// -----------------------------------------------------------------------------
module rgb_pwm_breathe #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic [1:0]       duty_sel,
  input  logic [WIDTH-1:0] duty_data,
  input  logic             enable,
`ifdef RGB_PWM_BREATHE_EN
  input  logic             breathe,
`endif
  output logic             pwm_r,
  output logic             pwm_g,
  output logic             pwm_b,
  output logic             period_start
);

  localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PH_MAX  = '1;

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] ph;
  logic             en_q;
  logic [WIDTH-1:0] shadow [3];
  logic [WIDTH-1:0] active [3];
  logic [WIDTH-1:0] blue_next;
  logic             run;
  logic             tick;
  logic             boundary;
  logic             rise;
  logic             commit;
  logic             wr;

  // The cycle in which enable rises keeps the counters at 0, so the following
  // cycle presents ph=0/pre=0 exactly like a normal period start.
  assign run      = enable && en_q;
  assign tick     = (pre == PRE_MAX);
  assign boundary = run && tick && (ph == PH_MAX);
  assign rise     = enable && !en_q;
  assign commit   = !rst && (boundary || rise);

  // Refusing writes on commit cycles means a shadow never changes while it is
  // being copied into the active registers.
  assign duty_ready = !commit;
  assign wr         = duty_valid && duty_ready;

  // ---------------------------------------------------------------------------
  // Prescaler and phase counter
  // ---------------------------------------------------------------------------
  // NOTE: registers are updated with non-blocking assignments so every
  // always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      pre  <= '0;
      ph   <= '0;
    end else begin
      en_q <= enable;
      if (!run) begin
        pre <= '0;
        ph  <= '0;
      end else if (tick) begin
        pre <= '0;
        ph  <= ph + WIDTH'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and active duty registers
  // ---------------------------------------------------------------------------
  // NOTE: these small register arrays are reset explicitly because the reset
  // state (all duties 0) is visible behaviour; a large RAM would not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr) begin
        case (duty_sel)
          2'd0:    shadow[0] <= duty_data;
          2'd1:    shadow[1] <= duty_data;
          2'd2:    shadow[2] <= duty_data;
          default: ;  // channel 3: accepted and dropped
        endcase
      end
      if (commit) begin
        active[0] <= shadow[0];
        active[1] <= shadow[1];
        active[2] <= blue_next;
      end
    end
  end

`ifdef RGB_PWM_BREATHE_EN
  // ---------------------------------------------------------------------------
  // Breathing engine: triangle ramp 0 -> max -> 0, one step per commit
  // ---------------------------------------------------------------------------
  typedef enum logic {UP, DOWN} breathe_state_t;

  breathe_state_t   state;
  breathe_state_t   state_next;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_next;
  logic             step;

  assign step = commit && breathe;

  // State register; frozen whenever breathe is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UP;
      level <= '0;
    end else if (step) begin
      state <= state_next;
      level <= level_next;
    end
  end

  // Next state: direction flips on the step that lands on an end stop.
  // NOTE: always_comb assigns a default to every output first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    level_next = level;
    case (state)
      UP: begin
        level_next = level + WIDTH'(1);
        if (level_next == PH_MAX) state_next = DOWN;
      end
      DOWN: begin
        level_next = level - WIDTH'(1);
        if (level_next == '0) state_next = UP;
      end
      default: state_next = UP;
    endcase
  end

  // Output: blue commits the new ramp level while breathing, else its shadow.
  always_comb begin
    blue_next = shadow[2];
    if (breathe) blue_next = level_next;
  end
`else
  assign blue_next = shadow[2];
`endif

  // ---------------------------------------------------------------------------
  // Registered compare and period_start pulse
  // ---------------------------------------------------------------------------
  // Gated by run rather than enable alone: the enable-rise cycle sits at ph=0
  // with the duty that is about to be replaced, and must not leak a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r        <= 1'b0;
      pwm_g        <= 1'b0;
      pwm_b        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_r        <= run && (ph < active[0]);
      pwm_g        <= run && (ph < active[1]);
      pwm_b        <= run && (ph < active[2]);
      period_start <= commit;
    end
  end

endmodule
